output_display_driver: RTL
==========================

Name: output_display_driver

Overview:
- Board-side output stage for the alarm-clock datapath.
- Takes the BCD time/setting value plus status from the control logic.
- Registers it, decodes it to four active-low seven-segment displays, blinks the digits being edited, and drives a walking red-LED pattern while the alarm sounds.
- Sits between the core and the board pins, mirroring the input stage that brings buttons, switches and clock in.

Parameters:
- BLINK_DIV, 25000000, clkIn cycles per blink half-period (0.5 s at 50 MHz); legal minimum 2.
- LED_WIDTH, 18, number of red LEDs driven by ledRedOut.

Ports:
- clkIn  input  1  system clock, all state on rising edge
- resetIn  input  1  asynchronous, active-low reset
- digitsIn  input  16  four BCD nibbles; [15:12] = digit 3 (leftmost) … [3:0] = digit 0
- updateIn  input  1  load strobe, one cycle; captures digitsIn into the shadow register
- blinkMaskIn  input  4  per-digit blink enable; bit i applies to digit i (sampled every cycle)
- alarmIn  input  1  level, alarm active
- hex0Out..hex3Out  output  7 each  active-low segments {g,f,e,d,c,b,a}
- ledRedOut  output  LED_WIDTH  walking alarm pattern
- blinkPhaseOut  output  1  current blink phase, 1 = blank half

Behaviour:
- Reset (resetIn = 0, asynchronous):
  - shadow = 0, valid = 0, blink counter = 0, phase = 0.
  - hex0Out..hex3Out = 7'h7F (all blank), ledRedOut = 0, blinkPhaseOut = 0.
  - Release is synchronous to the next clkIn edge.
- Display before first load: while valid = 0, all digits are blank regardless of other inputs.
- Load on updateIn = 1 at edge N:
  - shadow <= digitsIn, valid <= 1.
  - Decoded segments appear on hexOut after edge N+1; digitsIn-to-pin latency is 2 cycles.
  - digitsIn is ignored when updateIn = 0.
- Decode (active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Nibbles A–F display a dash, 0111111.
- Blink counter:
  - Counts 0..BLINK_DIV-1, then wraps to 0.
  - phase toggles on the wrap cycle, giving a period of 2*BLINK_DIV cycles.
  - The counter runs continuously after reset, independent of updateIn and alarmIn.
- Blanking:
  - Digit i outputs 7'h7F when blinkMaskIn[i] = 1 and phase = 1; otherwise it outputs the decoded value.
  - Blanking is applied in the same output register stage, so it has a 1-cycle latency from the mask/phase change.
- Alarm LEDs, state machine with states IDLE and WALK:
  - IDLE: ledRedOut = 0. Goes to WALK when alarmIn = 1, loading ledRedOut = 1 (bit 0 lit) on that edge.
  - WALK: on each phase toggle, ledRedOut rotates left by 1; bit LED_WIDTH-1 wraps to bit 0.
  - WALK: alarmIn = 0 returns to IDLE with ledRedOut = 0 on that edge.
  - Simultaneous alarm assertion and phase toggle: load 1, no rotate.
  - alarmIn deassert/reassert restarts from bit 0.
- blinkPhaseOut = phase register, no extra delay.
- Reset mid-operation: everything returns to reset values immediately; no partial display persists.

Test Plan (BLINK_DIV = 4 for sim):
- Reset then idle 20 cycles → all hexOut = 7F, ledRedOut = 0, blinkPhaseOut toggles at cycles 4, 8, 12, ….
- digitsIn = 16'h1234, updateIn pulse at edge N → at N+2, hex3..hex0 = 1111001, 0100100, 0110000, 0011001; change digitsIn without updateIn → display unchanged.
- Load 16'h9A05 → hex3 = 0010000, hex2 = 0111111 (dash), hex1 = 1000000, hex0 = 0010010.
- blinkMaskIn = 4'b0001 with 16'h1234 loaded → hex0 alternates 0011001 / 7F every 4 cycles, tracking blinkPhaseOut with 1-cycle lag; hex3..hex1 steady.
- alarmIn high for 80 cycles → ledRedOut = 18'h00001, then 00002, 00004, … per toggle; after 18 toggles it is back to 18'h00001; alarmIn low → 0 next edge.
- Assert resetIn = 0 mid-blink with alarm active → outputs go to 7F/0 asynchronously (before the next clkIn edge); after release, display stays blank until the next updateIn.

Source files
------------

// File: rtl/output_display_driver_if.sv
// ---------------------------------------------------------------------------
// output_display_driver_if
// Bundles the display driver's data/status inputs and board-pin outputs.
//
// Signals:
//   digitsIn      - four BCD nibbles, [15:12] is the leftmost digit
//   updateIn      - one-cycle load strobe for digitsIn
//   blinkMaskIn   - per-digit blink enable, bit i applies to digit i
//   alarmIn       - level, alarm currently sounding
//   hex0Out..3Out - active-low segments {g,f,e,d,c,b,a}
//   ledRedOut     - walking red-LED alarm pattern
//   blinkPhaseOut - current blink phase, 1 = blank half
//
// Modports:
//   master - the core side that drives the inputs and observes the pins
//   slave  - the display driver itself
// ---------------------------------------------------------------------------
interface output_display_driver_if #(
    parameter int LED_WIDTH = 18
);
    logic [15:0]          digitsIn;
    logic                 updateIn;
    logic [3:0]           blinkMaskIn;
    logic                 alarmIn;
    logic [6:0]           hex0Out;
    logic [6:0]           hex1Out;
    logic [6:0]           hex2Out;
    logic [6:0]           hex3Out;
    logic [LED_WIDTH-1:0] ledRedOut;
    logic                 blinkPhaseOut;

    modport master (
        output digitsIn, updateIn, blinkMaskIn, alarmIn,
        input  hex0Out, hex1Out, hex2Out, hex3Out, ledRedOut, blinkPhaseOut
    );

    modport slave (
        input  digitsIn, updateIn, blinkMaskIn, alarmIn,
        output hex0Out, hex1Out, hex2Out, hex3Out, ledRedOut, blinkPhaseOut
    );
endinterface

// File: rtl/output_display_driver.sv
// ---------------------------------------------------------------------------
// output_display_driver
// Board-side output stage of the alarm clock. Holds the last loaded BCD
// value, decodes it onto four active-low seven-segment displays, blanks the
// digits being edited on the blank half of the blink period, and walks a
// single lit red LED while the alarm is sounding.
//
// Ports:
//   clkIn   - system clock, all state changes on the rising edge
//   resetIn - asynchronous active-low reset
//   bus     - output_display_driver_if slave modport (data in, pins out)
//
// Parameters:
//   BLINK_DIV - clkIn cycles per blink half-period (minimum 2)
//   LED_WIDTH - number of red LEDs in the walking pattern
// ---------------------------------------------------------------------------
module output_display_driver #(
    parameter int BLINK_DIV = 25000000,
    parameter int LED_WIDTH = 18
) (
    input  logic                    clkIn,
    input  logic                    resetIn,
    output_display_driver_if.slave  bus
);

    localparam int             CNT_W   = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WALK = 1'b1;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [15:0]          shadow;
    logic                 valid;
    logic [CNT_W-1:0]     blink_cnt;
    logic                 phase;
    logic                 wrap;
    logic [6:0]           hex_q [4];
    logic [0:0]           led_state;
    logic [LED_WIDTH-1:0] led_q;

    // BCD to active-low segments; anything above 9 shows a dash so a
    // corrupted nibble is visible rather than silently blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // The blink phase flips on the same cycle the counter wraps; the LED
    // walker uses this as its step strobe.
    assign wrap = (blink_cnt == CNT_MAX);

    // Shadow register: only an update strobe may change what is displayed.
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            shadow <= '0;
            valid  <= 1'b0;
        end else if (bus.updateIn) begin
            shadow <= bus.digitsIn;
            valid  <= 1'b1;
        end
    end

    // Free-running blink divider, independent of loads and the alarm.
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (wrap) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
        end
    end

    // Output register stage: decode plus blanking, so the pins see the
    // shadow one cycle after it loads and react to mask/phase one cycle late.
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            for (int i = 0; i < 4; i++) begin
                hex_q[i] <= SEG_BLANK;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!valid || (bus.blinkMaskIn[i] && phase)) begin
                    hex_q[i] <= SEG_BLANK;
                end else begin
                    hex_q[i] <= seg_decode(shadow[4*i +: 4]);
                end
            end
        end
    end

    // Alarm LED walker. Entering WALK always starts at bit 0, even if a
    // phase toggle lands on the same edge; leaving clears the pattern.
    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            led_state <= IDLE;
            led_q     <= '0;
        end else begin
            case (led_state)
                IDLE: begin
                    if (bus.alarmIn) begin
                        led_state <= WALK;
                        led_q     <= LED_WIDTH'(1);
                    end else begin
                        led_q     <= '0;
                    end
                end
                default: begin
                    if (!bus.alarmIn) begin
                        led_state <= IDLE;
                        led_q     <= '0;
                    end else if (wrap) begin
                        led_q     <= {led_q[LED_WIDTH-2:0], led_q[LED_WIDTH-1]};
                    end
                end
            endcase
        end
    end

    assign bus.hex0Out       = hex_q[0];
    assign bus.hex1Out       = hex_q[1];
    assign bus.hex2Out       = hex_q[2];
    assign bus.hex3Out       = hex_q[3];
    assign bus.ledRedOut     = led_q;
    assign bus.blinkPhaseOut = phase;

endmodule
